// File: rtl/ifid_ctrl_pkg.sv
// rtl/ifid_ctrl_pkg.sv - shared state encoding and width defaults for the IF/ID hazard controller
package ifid_ctrl_pkg;

  localparam int DEF_PC_W   = 8;
  localparam int DEF_REG_AW = 6;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/ifid_hazard_ctrl_if.sv
// rtl/ifid_hazard_ctrl_if.sv - pipeline-side signals seen by the IF/ID hazard controller
interface ifid_hazard_ctrl_if
  import ifid_ctrl_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_halt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              imem_ready;
  logic              resume;
  logic              stat_clr;
  logic              pc_write_en;
  logic              pc_sel;
  logic [PC_W-1:0]   pc_target;
  logic              ifid_write_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_count;
  logic [1:0]        ctrl_state;

  // master = the controller, slave = the pipeline stages around it
  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, ex_mem_read, ex_rd,
           br_taken, br_target, imem_ready, resume, stat_clr,
    output pc_write_en, pc_sel, pc_target, ifid_write_en, ifid_flush,
           idex_bubble, stall_count, ctrl_state
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, ex_mem_read, ex_rd,
           br_taken, br_target, imem_ready, resume, stat_clr,
    input  pc_write_en, pc_sel, pc_target, ifid_write_en, ifid_flush,
           idex_bubble, stall_count, ctrl_state
  );

endinterface

// File: rtl/ifid_load_use_cmp.sv
// rtl/ifid_load_use_cmp.sv - combinational load-use hazard detect between EX load and ID sources
module ifid_load_use_cmp
  import ifid_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              hazard
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// rtl/ifid_hazard_ctrl.sv - PC / IF/ID advance-hold-flush sequencer with stall statistics
module ifid_hazard_ctrl
  import ifid_ctrl_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int REG_AW       = DEF_REG_AW,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  ifid_hazard_ctrl_if.master bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam ctrl_state_e REDIR_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  ctrl_state_e      state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]  pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_count_q;

  logic            hazard, redirect;
  logic            pc_we, pc_sel, ifid_we, ifid_fl, bubble;
  logic [PC_W-1:0] pc_tgt;

  ifid_load_use_cmp #(.REG_AW(REG_AW)) u_cmp (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .hazard      (hazard)
  );

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    redirect      = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    pc_tgt        = bus.br_target;
    ifid_we       = 1'b0;
    ifid_fl       = 1'b0;
    bubble        = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.br_taken) begin
          redirect = 1'b1;
        end else if (hazard) begin
          bubble = 1'b1;
        end else if (bus.id_halt) begin
          bubble  = 1'b1;
          state_d = ST_HALT;
        end else if (!bus.imem_ready) begin
          ifid_fl = 1'b1;
          state_d = ST_IMEM_WAIT;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      ST_FLUSH: begin
        ifid_fl = 1'b1;
        pc_we   = bus.imem_ready;
        if (bus.br_taken) begin
          redirect = 1'b1;
        end else if (bus.imem_ready) begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
          if (flush_cnt_q == FC_W'(1)) state_d = ST_RUN;
        end
      end
      ST_IMEM_WAIT: begin
        ifid_fl = 1'b1;
        // a branch arriving on the ready cycle is newer than any pending one
        if (bus.imem_ready && (bus.br_taken || pend_valid_q)) begin
          redirect     = 1'b1;
          pend_valid_d = 1'b0;
          if (!bus.br_taken) pc_tgt = pend_target_q;
        end else if (bus.imem_ready) begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          ifid_fl = 1'b0;
          state_d = ST_RUN;
        end else if (bus.br_taken) begin
          pend_valid_d  = 1'b1;
          pend_target_d = bus.br_target;
        end
      end
      ST_HALT: begin
        bubble = 1'b1;
        if (bus.br_taken) redirect = 1'b1;
        else if (bus.resume) state_d = ST_RUN;
      end
    endcase
    if (redirect) begin
      pc_we       = 1'b1;
      pc_sel      = 1'b1;
      ifid_fl     = 1'b1;
      bubble      = 1'b1;
      state_d     = REDIR_NEXT;
      flush_cnt_d = FLUSH_RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if (bus.stat_clr)
        stall_count_q <= '0;
      else if (!pc_we && (state_q != ST_HALT) && (stall_count_q != '1))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  // while in reset the pipeline is held with NOPs in IF/ID and ID/EX
  assign bus.pc_write_en   = rst_n & pc_we;
  assign bus.pc_sel        = rst_n & pc_sel;
  assign bus.ifid_write_en = rst_n & ifid_we;
  assign bus.ifid_flush    = ~rst_n | ifid_fl;
  assign bus.idex_bubble   = ~rst_n | bubble;
  assign bus.pc_target     = pc_tgt;
  assign bus.stall_count   = stall_count_q;
  assign bus.ctrl_state    = state_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb/tb_ifid_hazard_ctrl.sv - self-checking bench for ifid_hazard_ctrl
module tb_ifid_hazard_ctrl;
  localparam int PC_W = 8;
  localparam int REG_AW = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [4:0] ctl;

  always #5 clk = ~clk;

  ifid_hazard_ctrl_if #(.PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  ifid_hazard_ctrl #(
    .PC_W(PC_W), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // {pc_write_en, pc_sel, ifid_write_en, ifid_flush, idex_bubble}
  assign ctl = {bus.pc_write_en, bus.pc_sel, bus.ifid_write_en, bus.ifid_flush, bus.idex_bubble};

  task automatic idle;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_halt = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.imem_ready = 1'b1;
    bus.resume = 1'b0; bus.stat_clr = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.ctrl_state); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.stall_count); end
    tick();
    bus.br_taken = 1'b1; bus.br_target = 8'h40;
    tick();
    bus.br_taken = 1'b0; bus.imem_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd1) begin errors++; $display("FAIL pre_rst_flush got %0d exp 1", bus.ctrl_state); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL midflush_rst_state got %0d exp 0", bus.ctrl_state); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL midflush_rst_count got %0d exp 0", bus.stall_count); end
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL rst_outputs got %b exp 00011", ctl); end
  endtask

  task automatic test_load_use;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 6'd5; bus.id_rs = 6'd5; bus.id_uses_rs = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL loaduse_rs_ctl got %b exp 00001", ctl); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL loaduse_cnt0 got %0d exp 0", bus.stall_count); end
    tick();
    bus.ex_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL loaduse_cnt1 got %0d exp 1", bus.stall_count); end
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL loaduse_release got %b exp 10100", ctl); end
    tick();
    bus.ex_mem_read = 1'b1; bus.id_uses_rs = 1'b0; bus.id_rs = 6'd3;
    bus.id_uses_rt = 1'b1; bus.id_rt = 6'd5;
    @(negedge clk);
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL loaduse_rt_ctl got %b exp 00001", ctl); end
  endtask

  task automatic test_rd_zero;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL rd0_ctl got %b exp 10100", ctl); end
    tick();
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL rd0_cnt got %0d exp 0", bus.stall_count); end
  endtask

  task automatic test_branch;
    do_reset();
    bus.br_taken = 1'b1; bus.br_target = 8'h40;
    @(negedge clk);
    checks++; if (ctl !== 5'b11011) begin errors++; $display("FAIL br_ctl got %b exp 11011", ctl); end
    checks++; if (bus.pc_target !== 8'h40) begin errors++; $display("FAIL br_target got %h exp 40", bus.pc_target); end
    tick();
    bus.br_taken = 1'b0; bus.br_target = '0;
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd1) begin errors++; $display("FAIL br_flush_state got %0d exp 1", bus.ctrl_state); end
    checks++; if (ctl !== 5'b10010) begin errors++; $display("FAIL br_flush2_ctl got %b exp 10010", ctl); end
    tick();
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL br_back_run got %0d exp 0", bus.ctrl_state); end
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL br_run_ctl got %b exp 10100", ctl); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.br_taken = 1'b1; bus.br_target = 8'h40;
    tick();
    bus.br_target = 8'h55;
    @(negedge clk);
    checks++; if (ctl !== 5'b11011) begin errors++; $display("FAIL b2b_ctl got %b exp 11011", ctl); end
    checks++; if (bus.pc_target !== 8'h55) begin errors++; $display("FAIL b2b_target got %h exp 55", bus.pc_target); end
    tick();
    bus.br_taken = 1'b0;
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd1) begin errors++; $display("FAIL b2b_reload got %0d exp 1", bus.ctrl_state); end
    tick();
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd0) begin errors++; $display("FAIL b2b_run got %0d exp 0", bus.ctrl_state); end
  endtask

  task automatic test_imem_wait;
    do_reset();
    bus.imem_ready = 1'b0;
    @(negedge clk);
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL iw_c1 got %b exp 00010", ctl); end
    tick();
    bus.br_taken = 1'b1; bus.br_target = 8'h20;
    @(negedge clk);
    checks++; if (ctl !== 5'b00010 || bus.ctrl_state !== 2'd2) begin errors++; $display("FAIL iw_c2 got %b/%0d exp 00010/2", ctl, bus.ctrl_state); end
    tick();
    bus.br_taken = 1'b0; bus.br_target = 8'h00;
    @(negedge clk);
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL iw_c3 got %b exp 00010", ctl); end
    tick();
    bus.imem_ready = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== 5'b11011) begin errors++; $display("FAIL iw_redir_ctl got %b exp 11011", ctl); end
    checks++; if (bus.pc_target !== 8'h20) begin errors++; $display("FAIL iw_redir_target got %h exp 20", bus.pc_target); end
    checks++; if (bus.stall_count !== 4'd3) begin errors++; $display("FAIL iw_cnt got %0d exp 3", bus.stall_count); end
    tick();
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd1) begin errors++; $display("FAIL iw_flush got %0d exp 1", bus.ctrl_state); end
  endtask

  task automatic test_halt;
    do_reset();
    bus.id_halt = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL halt_enter_ctl got %b exp 00001", ctl); end
    tick();
    bus.id_halt = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd3) begin errors++; $display("FAIL halt_state got %0d exp 3", bus.ctrl_state); end
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL halt_cnt_frozen got %0d exp 1", bus.stall_count); end
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL halt_ctl got %b exp 00001", ctl); end
    tick();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    @(negedge clk);
    checks++; if (bus.ctrl_state !== 2'd0 || ctl !== 5'b10100) begin errors++; $display("FAIL resume got %0d/%b exp 0/10100", bus.ctrl_state, ctl); end
  endtask

  task automatic test_saturation;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 6'd9; bus.id_rt = 6'd9; bus.id_uses_rt = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'hF) begin errors++; $display("FAIL sat_cnt got %h exp F", bus.stall_count); end
    tick();
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0; bus.ex_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL sat_clr got %h exp 0", bus.stall_count); end
  endtask

  // Reference: the controller is in one of four modes; each cycle picks one action
  // (advance, redirect, stall, wait, flush tick) and the outputs follow from the action.
  task automatic test_random;
    int ms, mf, mc, nxt;
    bit mpv;
    logic [7:0] mpt;
    do_reset();
    ms = 0; mf = 0; mc = 0; mpv = 1'b0; mpt = '0;
    for (int i = 0; i < 400; i++) begin
      bit hz, redir, adv, bub, fl, pwe;
      logic [7:0] tgt;
      logic [4:0] exp_ctl;
      bus.id_rs = REG_AW'($urandom_range(0, 3));
      bus.id_rt = REG_AW'($urandom_range(0, 3));
      bus.ex_rd = REG_AW'($urandom_range(0, 3));
      bus.id_uses_rs = 1'($urandom_range(0, 1));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.id_halt = ($urandom_range(0, 15) == 0);
      bus.br_taken = ($urandom_range(0, 7) == 0);
      bus.br_target = 8'($urandom);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.resume = ($urandom_range(0, 3) == 0);
      bus.stat_clr = ($urandom_range(0, 31) == 0);
      hz = bus.ex_mem_read && (bus.ex_rd != 0) &&
           ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) || (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
      redir = 0; adv = 0; bub = 0; fl = 0; pwe = 0; tgt = bus.br_target; nxt = ms;
      case (ms)
        0: if (bus.br_taken) redir = 1;
           else if (hz) bub = 1;
           else if (bus.id_halt) begin bub = 1; nxt = 3; end
           else if (!bus.imem_ready) begin fl = 1; nxt = 2; end
           else adv = 1;
        1: if (bus.br_taken) redir = 1;
           else begin
             fl = 1; pwe = bus.imem_ready;
             if (bus.imem_ready) begin mf = mf - 1; if (mf == 0) nxt = 0; end
           end
        2: if (bus.imem_ready && (bus.br_taken || mpv)) begin
             redir = 1; if (!bus.br_taken) tgt = mpt; mpv = 0;
           end else if (bus.imem_ready) begin adv = 1; nxt = 0; end
           else begin fl = 1; if (bus.br_taken) begin mpv = 1; mpt = bus.br_target; end end
        default: if (bus.br_taken) redir = 1;
                 else begin bub = 1; if (bus.resume) nxt = 0; end
      endcase
      if (redir) begin
        pwe = 1; fl = 1; bub = 1;
        nxt = (FLUSH_CYCLES > 1) ? 1 : 0;
        mf = FLUSH_CYCLES - 1;
      end
      if (adv) pwe = 1;
      exp_ctl = {pwe, redir, adv, fl, bub};
      @(negedge clk);
      checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rand_ctl cyc %0d got %b exp %b", i, ctl, exp_ctl); end
      checks++; if (bus.pc_target !== tgt) begin errors++; $display("FAIL rand_target cyc %0d got %h exp %h", i, bus.pc_target, tgt); end
      checks++; if (bus.ctrl_state !== 2'(ms)) begin errors++; $display("FAIL rand_state cyc %0d got %0d exp %0d", i, bus.ctrl_state, ms); end
      checks++; if (bus.stall_count !== 4'(mc)) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", i, bus.stall_count, mc); end
      if (bus.stat_clr) mc = 0;
      else if (!pwe && ms != 3 && mc < 15) mc = mc + 1;
      ms = nxt;
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_back_to_back();
    test_imem_wait();
    test_halt();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
